// File: rtl/rgb_to_yuv_encoder.sv
// RGB -> YUV 4:2:2 encoder: streams 4-pixel groups from the interleaved RGB region
// and writes Y/U/V planes, overlapping group k writes with group k+1 reads.
module rgb_to_yuv_encoder #(
    parameter logic [17:0] Y_BASE     = 18'd0,
    parameter logic [17:0] U_BASE     = 18'd38400,
    parameter logic [17:0] V_BASE     = 18'd57600,
    parameter logic [17:0] RGB_BASE   = 18'd146944,
    parameter int          NUM_PIXELS = 76800
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Enable,
    output logic [17:0] SRAM_address,
    input  logic [15:0] SRAM_read_data,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        Done
);
    localparam int NUM_GROUPS = NUM_PIXELS / 4;
    localparam int GW = $clog2(NUM_GROUPS + 2);
    localparam logic [GW-1:0] LAST_GRP = GW'(NUM_GROUPS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state;
    logic [3:0]      slot;
    logic [GW-1:0]   per;
    logic [17:0]     rd_ptr;
    logic [17:0]     wr_off;
    logic [5:0][15:0] word;
    logic [3:0][7:0] res_y, res_u, res_v;
    logic [15:0]     out_y0, out_y1, out_u, out_v;

    // A 12-slot period p: slots 0-5 read group p, slots 2-7 capture it, slots 4..(next)3
    // run its 12 conversions, and slots 6-9 of period p+1 write its four words.
    logic       rd_slot, cap_slot, job_vld, latch, wr_slot, last_wr;
    logic [3:0] job;
    logic [1:0] job_pix, job_ch;

    assign rd_slot  = (per < LAST_GRP) && (slot <= 4'd5);
    assign cap_slot = (per < LAST_GRP) && (slot >= 4'd2) && (slot <= 4'd7);
    assign job      = (slot >= 4'd4) ? slot - 4'd4 : slot + 4'd8;
    assign job_pix  = 2'(job / 4'd3);
    assign job_ch   = 2'(job % 4'd3);
    assign job_vld  = (slot >= 4'd4) ? (per < LAST_GRP) : (per != '0);
    assign latch    = (per != '0) && (slot == 4'd4);
    assign wr_slot  = (per != '0) && (slot >= 4'd6) && (slot <= 4'd9);
    assign last_wr  = (per == LAST_GRP) && (slot == 4'd9);

    logic [7:0]         pr, pg, pb, res8;
    logic signed [31:0] cr, cg, cb, off, r32, g32, b32, acc, sc, val;

    always_comb begin
        pr = '0; pg = '0; pb = '0;
        case (job_pix)
            2'd0: begin pr = word[0][15:8]; pg = word[0][7:0];  pb = word[1][15:8]; end
            2'd1: begin pr = word[1][7:0];  pg = word[2][15:8]; pb = word[2][7:0];  end
            2'd2: begin pr = word[3][15:8]; pg = word[3][7:0];  pb = word[4][15:8]; end
            default: begin pr = word[4][7:0]; pg = word[5][15:8]; pb = word[5][7:0]; end
        endcase
        case (job_ch)
            2'd0:    begin cr = 32'sd16843;  cg = 32'sd33030;  cb = 32'sd6423;   off = 32'sd16;  end
            2'd1:    begin cr = -32'sd9699;  cg = -32'sd19071; cb = 32'sd28770;  off = 32'sd128; end
            default: begin cr = 32'sd28770;  cg = -32'sd24117; cb = -32'sd4653;  off = 32'sd128; end
        endcase
        r32 = $signed({24'd0, pr});
        g32 = $signed({24'd0, pg});
        b32 = $signed({24'd0, pb});
        acc = cr * r32 + cg * g32 + cb * b32 + 32'sd32768;
        sc  = acc >>> 16;
        val = sc + off;
        if (val < 0)              res8 = 8'h00;
        else if (val > 32'sd255)  res8 = 8'hFF;
        else                      res8 = val[7:0];
    end

    function automatic logic [7:0] avg2(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + 9'd1;
        return s[8:1];
    endfunction

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state           <= S_IDLE;
            slot            <= '0;
            per             <= '0;
            rd_ptr          <= '0;
            wr_off          <= '0;
            word            <= '0;
            res_y           <= '0;
            res_u           <= '0;
            res_v           <= '0;
            out_y0          <= '0;
            out_y1          <= '0;
            out_u           <= '0;
            out_v           <= '0;
            SRAM_address    <= '0;
            SRAM_write_data <= '0;
            SRAM_we_n       <= 1'b1;
            Done            <= 1'b0;
        end else begin
            SRAM_we_n <= 1'b1;
            Done      <= 1'b0;
            case (state)
                S_IDLE: if (Enable) begin
                    state  <= S_RUN;
                    slot   <= '0;
                    per    <= '0;
                    rd_ptr <= RGB_BASE;
                    wr_off <= '0;
                end
                S_RUN: begin
                    if (slot == 4'd11) begin
                        slot <= '0;
                        per  <= per + 1'b1;
                    end else begin
                        slot <= slot + 4'd1;
                    end
                    if (rd_slot) begin
                        SRAM_address <= rd_ptr;
                        rd_ptr       <= rd_ptr + 18'd1;
                    end
                    if (cap_slot) word[3'(slot - 4'd2)] <= SRAM_read_data;
                    if (job_vld) begin
                        case (job_ch)
                            2'd0:    res_y[job_pix] <= res8;
                            2'd1:    res_u[job_pix] <= res8;
                            default: res_v[job_pix] <= res8;
                        endcase
                    end
                    // Snapshot before the next group's conversions overwrite the results
                    if (latch) begin
                        out_y0 <= {res_y[0], res_y[1]};
                        out_y1 <= {res_y[2], res_y[3]};
                        out_u  <= {avg2(res_u[0], res_u[1]), avg2(res_u[2], res_u[3])};
                        out_v  <= {avg2(res_v[0], res_v[1]), avg2(res_v[2], res_v[3])};
                    end
                    if (wr_slot) begin
                        SRAM_we_n <= 1'b0;
                        case (slot)
                            4'd6: begin SRAM_address <= Y_BASE + wr_off + wr_off;         SRAM_write_data <= out_y0; end
                            4'd7: begin SRAM_address <= Y_BASE + wr_off + wr_off + 18'd1; SRAM_write_data <= out_y1; end
                            4'd8: begin SRAM_address <= U_BASE + wr_off;                  SRAM_write_data <= out_u;  end
                            default: begin
                                SRAM_address    <= V_BASE + wr_off;
                                SRAM_write_data <= out_v;
                                wr_off          <= wr_off + 18'd1;
                            end
                        endcase
                    end
                    if (last_wr) state <= S_DONE;
                end
                default: begin
                    Done  <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
